// File: rtl/traffic_spawn_scheduler.sv
// Spawn scheduler for AI traffic: after a frame gap, scans car slots for a free one,
// picks an unoccupied lane starting at a random base, then hands the spawn off.
// Optional TRAFFIC_DENSITY_RAMP_EN halves the spawn gap at high player speed.
module traffic_spawn_scheduler #(
    parameter int NUM_SLOTS        = 4,
    parameter int SPAWN_GAP_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [NUM_SLOTS-1:0] slot_free,
    input  logic [3:0]           lane_busy,
    input  logic [10:0]          random,
    input  logic [9:0]           player_speed,
    input  logic                 spawn_ready,
    output logic                 spawn_valid,
    output logic [2:0]           spawn_slot,
    output logic [10:0]          spawn_x,
    output logic [7:0]           spawn_count,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, SCAN, PICK, ISSUE} state_t;

    localparam logic [7:0] GAP_FULL = 8'(SPAWN_GAP_FRAMES);
    localparam logic [7:0] GAP_HALF = (SPAWN_GAP_FRAMES / 2 < 1) ? 8'd1 : 8'(SPAWN_GAP_FRAMES / 2);
    localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

    state_t      state_q, state_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [2:0]  slot_idx_q, slot_idx_d;
    logic [1:0]  try_q, try_d;
    logic [1:0]  base_q, base_d;
    logic        valid_q, valid_d;
    logic [2:0]  slot_q, slot_d;
    logic [10:0] x_q, x_d;
    logic [7:0]  count_q, count_d;

    logic [7:0]  free_pad;
    logic [1:0]  lane;
    logic [10:0] lane_x;
    logic [7:0]  eff_gap;

`ifdef TRAFFIC_DENSITY_RAMP_EN
    assign eff_gap = player_speed[9] ? GAP_HALF : GAP_FULL;
    logic unused_bits;
    assign unused_bits = ^random[10:2];
`else
    assign eff_gap = GAP_FULL;
    logic unused_bits;
    assign unused_bits = ^{random[10:2], player_speed, GAP_HALF};
`endif

    // Pad slot_free to 8 bits so the 3-bit slot index never selects out of range.
    always_comb begin
        free_pad = '0;
        free_pad[NUM_SLOTS-1:0] = slot_free;
    end

    assign lane = base_q + try_q;

    always_comb begin
        case (lane)
            2'd0:    lane_x = 11'd180;
            2'd1:    lane_x = 11'd240;
            2'd2:    lane_x = 11'd300;
            default: lane_x = 11'd360;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;
        slot_idx_d = slot_idx_q;
        try_d      = try_q;
        base_d     = base_q;
        valid_d    = valid_q;
        slot_d     = slot_q;
        x_d        = x_q;
        count_d    = count_q;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    if (gap_cnt_q != 8'd0) begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end else begin
                        state_d    = SCAN;
                        slot_idx_d = 3'd0;
                    end
                end
            end
            SCAN: begin
                if (free_pad[slot_idx_q]) begin
                    slot_d  = slot_idx_q;
                    base_d  = random[1:0];
                    try_d   = 2'd0;
                    state_d = PICK;
                end else if (slot_idx_q != LAST_SLOT) begin
                    slot_idx_d = slot_idx_q + 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            PICK: begin
                if (!lane_busy[lane]) begin
                    x_d     = lane_x;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end else if (try_q != 2'd3) begin
                    try_d = try_q + 2'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (spawn_ready) begin
                    gap_cnt_d = eff_gap;
                    valid_d   = 1'b0;
                    state_d   = IDLE;
                    if (count_q != 8'd255) count_d = count_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gap_cnt_q  <= '0;
            slot_idx_q <= '0;
            try_q      <= '0;
            base_q     <= '0;
            valid_q    <= 1'b0;
            slot_q     <= '0;
            x_q        <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            gap_cnt_q  <= gap_cnt_d;
            slot_idx_q <= slot_idx_d;
            try_q      <= try_d;
            base_q     <= base_d;
            valid_q    <= valid_d;
            slot_q     <= slot_d;
            x_q        <= x_d;
            count_q    <= count_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_slot  = slot_q;
    assign spawn_x     = x_q;
    assign spawn_count = count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_traffic_spawn_scheduler.sv
// Directed-vector bench for traffic_spawn_scheduler; expected values are hand-computed.
module tb_traffic_spawn_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [3:0]  slot_free;
    logic [3:0]  lane_busy;
    logic [10:0] random;
    logic [9:0]  player_speed;
    logic        spawn_ready;
    logic        spawn_valid;
    logic [2:0]  spawn_slot;
    logic [10:0] spawn_x;
    logic [7:0]  spawn_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

`ifdef TRAFFIC_DENSITY_RAMP_EN
    localparam int BLOCKED = 4;
`else
    localparam int BLOCKED = 8;
`endif

    traffic_spawn_scheduler #(.NUM_SLOTS(4), .SPAWN_GAP_FRAMES(8)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .slot_free(slot_free),
        .lane_busy(lane_busy), .random(random), .player_speed(player_speed),
        .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .spawn_slot(spawn_slot),
        .spawn_x(spawn_x), .spawn_count(spawn_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    // Steps until spawn_valid is seen, reporting the number of steps taken.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!spawn_valid && n < limit) begin
            step();
            n++;
        end
        if (!spawn_valid) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    int n;
    int seen;

    initial begin
        reset = 1'b1; frame_start = 1'b0; slot_free = 4'b0001; lane_busy = 4'b0000;
        random = 11'd2; player_speed = 10'd600; spawn_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(spawn_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(spawn_count), 32'd0);
        chk("rst_slot", 32'(spawn_slot), 32'd0);
        chk("rst_x", 32'(spawn_x), 32'd0);
        step();
        reset = 1'b0;
        step();

        // Minimum latency path: slot 0 free, base lane 2 free.
        pulse();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_v_c1", 32'(spawn_valid), 32'd0);
        step();
        chk("t1_v_c2", 32'(spawn_valid), 32'd0);
        step();
        chk("t1_v_c3", 32'(spawn_valid), 32'd1);
        chk("t1_slot", 32'(spawn_slot), 32'd0);
        chk("t1_x", 32'(spawn_x), 32'd300);
        step();
        chk("t1_v_after", 32'(spawn_valid), 32'd0);
        chk("t1_count", 32'(spawn_count), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // Gap: frames during the gap are swallowed, the next one scans.
        seen = 0;
        for (int k = 0; k < BLOCKED; k++) begin
            pulse();
            if (busy) seen++;
            step();
        end
        chk("gap_blocked", 32'(seen), 32'd0);
        pulse();
        chk("gap_scan", 32'(busy), 32'd1);
        wait_valid(10, n);
        step();
        chk("gap_count", 32'(spawn_count), 32'd2);

        // Slot 3 only, base 1, lanes 1 and 2 busy -> lane 3.
        do_reset();
        slot_free = 4'b1000; random = 11'd1; lane_busy = 4'b0110; spawn_ready = 1'b0;
        pulse();
        wait_valid(20, n);
        chk("t2_latency", 32'(n), 32'd7);
        chk("t2_slot", 32'(spawn_slot), 32'd3);
        chk("t2_x", 32'(spawn_x), 32'd360);
        spawn_ready = 1'b1;
        step();
        chk("t2_count", 32'(spawn_count), 32'd1);
        chk("t2_v_after", 32'(spawn_valid), 32'd0);

        // All lanes busy: give up without spawning or reloading the gap.
        do_reset();
        slot_free = 4'b1111; lane_busy = 4'b1111; random = 11'd0;
        pulse();
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (spawn_valid) seen++;
            step();
        end
        chk("t3_no_valid", 32'(seen), 32'd0);
        chk("t3_idle", 32'(busy), 32'd0);
        chk("t3_count", 32'(spawn_count), 32'd0);
        lane_busy = 4'b0000;
        pulse();
        chk("t3_rescan", 32'(busy), 32'd1);
        wait_valid(10, n);
        chk("t3_slot", 32'(spawn_slot), 32'd0);
        chk("t3_x", 32'(spawn_x), 32'd180);
        step();
        chk("t3_count2", 32'(spawn_count), 32'd1);

        // Stalled handshake is stable; async reset cancels it.
        do_reset();
        slot_free = 4'b0100; lane_busy = 4'b0000; random = 11'd3; spawn_ready = 1'b0;
        pulse();
        wait_valid(10, n);
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (!spawn_valid || spawn_slot != 3'd2 || spawn_x != 11'd360) seen++;
        end
        chk("t4_stable", 32'(seen), 32'd0);
        chk("t4_x", 32'(spawn_x), 32'd360);
        chk("t4_count_hold", 32'(spawn_count), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_rst_valid", 32'(spawn_valid), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_count", 32'(spawn_count), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("t4_post_valid", 32'(spawn_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
